// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter and sequencer sharing one block_ram
// between two requesters. Read data returns one cycle after acceptance
// through registered response ports.
//
// Optional feature macro: RAM_ARB_CLEAR_EN
//    defined   -> after every reset the RAM is zero-filled (busy=1) before
//                 any grant is given
//    undefined -> requests are granted from the first cycle after reset and
//                 RAM contents survive reset
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zero-fill sweep, one address per cycle, no grants
// ST_RUN   | normal arbitration between requester 0 and requester 1
//
// Without the macro only ST_RUN exists, so it is implicit.
module ram_arbiter #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 128,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  req0_valid,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [WIDTH-1:0]      req0_wdata,
   output logic                  req0_ready,

   input  logic                  req1_valid,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [WIDTH-1:0]      req1_wdata,
   output logic                  req1_ready,

   output logic                  rsp0_valid,
   output logic [WIDTH-1:0]      rsp0_rdata,
   output logic                  rsp1_valid,
   output logic [WIDTH-1:0]      rsp1_rdata,

   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [WIDTH-1:0]      ram_wr_data,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [WIDTH-1:0]      ram_rd_data,

   output logic                  busy
);

   // A RAM deeper than the address space cannot be fully reached.
   if (DEPTH > (2 ** ADDR_WIDTH)) begin : g_depth_check
      $error("ram_arbiter: DEPTH exceeds 2**ADDR_WIDTH");
   end

   logic                  w_run;
   logic                  w_clearing;
   logic [ADDR_WIDTH-1:0] w_clr_addr;

   logic                  r_last_grant;
   logic                  w_gnt0;
   logic                  w_gnt1;
   logic                  w_rd0;
   logic                  w_rd1;

   logic                  r_rsp0_valid;
   logic [WIDTH-1:0]      r_rsp0_rdata;
   logic                  r_rsp1_valid;
   logic [WIDTH-1:0]      r_rsp1_rdata;

`ifdef RAM_ARB_CLEAR_EN
   localparam logic [0:0]            ST_CLEAR  = 1'b0;
   localparam logic [0:0]            ST_RUN    = 1'b1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   logic [0:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_clr_addr;

   // Sweep FSM: reset always restarts the zero-fill at address 0; the
   // counter stops at the last word instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
      end else if (r_state == ST_CLEAR) begin
         if (r_clr_addr == LAST_ADDR) begin
            r_state <= ST_RUN;
         end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
         end
      end
   end

   assign w_clearing = ~rst & (r_state == ST_CLEAR);
   assign w_run      = ~rst & (r_state == ST_RUN);
   assign w_clr_addr = r_clr_addr;
   assign busy       = rst | (r_state == ST_CLEAR);
`else
   assign w_clearing = 1'b0;
   assign w_run      = ~rst;
   assign w_clr_addr = '0;
   assign busy       = 1'b0;
`endif

   // Round robin: a lone request always wins; on a tie the requester that
   // was not granted last goes first (r_last_grant=1 means requester 1).
   assign w_gnt0 = w_run & req0_valid & (~req1_valid |  r_last_grant);
   assign w_gnt1 = w_run & req1_valid & (~req0_valid | ~r_last_grant);

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;

   assign w_rd0 = w_gnt0 & ~req0_we;
   assign w_rd1 = w_gnt1 & ~req1_we;

   // Remember the most recent winner; reset favours requester 0 first.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= 1'b1;
      end else if (w_gnt0) begin
         r_last_grant <= 1'b0;
      end else if (w_gnt1) begin
         r_last_grant <= 1'b1;
      end
   end

   // RAM port steering: sweep writes, else the single granted request.
   // Idle ports are driven to zero so the RAM never sees stale addresses.
   always_comb begin
      ram_wr_en   = 1'b0;
      ram_wr_addr = '0;
      ram_wr_data = '0;
      ram_rd_addr = '0;
      if (w_clearing) begin
         ram_wr_en   = 1'b1;
         ram_wr_addr = w_clr_addr;
      end else if (w_gnt0) begin
         if (req0_we) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = req0_addr;
            ram_wr_data = req0_wdata;
         end else begin
            ram_rd_addr = req0_addr;
         end
      end else if (w_gnt1) begin
         if (req1_we) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = req1_addr;
            ram_wr_data = req1_wdata;
         end else begin
            ram_rd_addr = req1_addr;
         end
      end
   end

   // Response registers: capture combinational RAM data at the accepting
   // edge and pulse valid for one cycle; data holds between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp0_valid <= 1'b0;
         r_rsp0_rdata <= '0;
         r_rsp1_valid <= 1'b0;
         r_rsp1_rdata <= '0;
      end else begin
         r_rsp0_valid <= w_rd0;
         r_rsp1_valid <= w_rd1;
         if (w_rd0) begin
            r_rsp0_rdata <= ram_rd_data;
         end
         if (w_rd1) begin
            r_rsp1_rdata <= ram_rd_data;
         end
      end
   end

   // A response registered just before reset rises must not escape while
   // reset is held, so the outputs are masked by rst as well.
   assign rsp0_valid = r_rsp0_valid & ~rst;
   assign rsp1_valid = r_rsp1_valid & ~rst;
   assign rsp0_rdata = rst ? '0 : r_rsp0_rdata;
   assign rsp1_rdata = rst ? '0 : r_rsp1_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a behavioural
// block_ram attached. Expected read data is queued at acceptance and
// compared when the response pulse appears.
module tb_ram_arbiter;
   localparam int WIDTH = 8;
   localparam int DEPTH = 128;
   localparam int AW    = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req0_we, req1_valid, req1_we;
   logic [AW-1:0]    req0_addr, req1_addr;
   logic [WIDTH-1:0] req0_wdata, req1_wdata;
   logic             req0_ready, req1_ready;
   logic             rsp0_valid, rsp1_valid;
   logic [WIDTH-1:0] rsp0_rdata, rsp1_rdata;
   logic             ram_wr_en;
   logic [AW-1:0]    ram_wr_addr, ram_rd_addr;
   logic [WIDTH-1:0] ram_wr_data, ram_rd_data;
   logic             busy;

   always #5 clk = ~clk;

   ram_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
      .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr),
      .ram_rd_data(ram_rd_data), .busy(busy)
   );

   // Attached RAM: synchronous write, combinational read.
   logic [WIDTH-1:0] tb_ram [0:255];
   logic             fill_en = 1'b0;
   logic             fill_ff = 1'b0;
   always @(posedge clk) begin
      if (fill_en) begin
         for (int i = 0; i < 256; i++) tb_ram[i] <= fill_ff ? 8'hFF : (8'(i) ^ 8'h5A);
      end else if (ram_wr_en) begin
         tb_ram[ram_wr_addr] <= ram_wr_data;
      end
   end
   assign ram_rd_data = tb_ram[ram_rd_addr];

   // Scoreboard state
   logic [WIDTH-1:0] exp_mem [0:255];
   logic [WIDTH-1:0] q0 [$];
   logic [WIDTH-1:0] q1 [$];
   bit               tb_last = 1'b1;
   bit               pend0 = 1'b0, pend1 = 1'b0;
   int               clr_cnt = 0;
   int               n_checks = 0;
   int               n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Per-cycle model: expected grants, RAM port drive and response timing.
   bit e0, e1, run;
   always @(negedge clk) begin
      if (rst) begin
         pend0 = 1'b0; pend1 = 1'b0;
         q0.delete(); q1.delete();
         tb_last = 1'b1;
         clr_cnt = 0;
         chk("rst_rsp0_valid", rsp0_valid, 0);
         chk("rst_rsp1_valid", rsp1_valid, 0);
         chk("rst_ready0", req0_ready, 0);
         chk("rst_ready1", req1_ready, 0);
         chk("rst_wr_en", ram_wr_en, 0);
`ifdef RAM_ARB_CLEAR_EN
         chk("rst_busy", busy, 1);
`else
         chk("rst_busy", busy, 0);
`endif
      end else begin
         if (pend0) begin
            chk("rsp0_valid", rsp0_valid, 1);
            chk("rsp0_rdata", rsp0_rdata, q0.pop_front());
         end else if (rsp0_valid) chk("rsp0_spurious", rsp0_valid, 0);
         if (pend1) begin
            chk("rsp1_valid", rsp1_valid, 1);
            chk("rsp1_rdata", rsp1_rdata, q1.pop_front());
         end else if (rsp1_valid) chk("rsp1_spurious", rsp1_valid, 0);
`ifdef RAM_ARB_CLEAR_EN
         run = (clr_cnt >= DEPTH);
         if (!run) begin
            chk("clr_busy", busy, 1);
            chk("clr_wr_en", ram_wr_en, 1);
            chk("clr_wr_addr", ram_wr_addr, clr_cnt);
            chk("clr_wr_data", ram_wr_data, 0);
            if (req0_valid) chk("clr_ready0", req0_ready, 0);
            if (req1_valid) chk("clr_ready1", req1_ready, 0);
            clr_cnt++;
            if (clr_cnt == DEPTH) for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
         end
`else
         run = 1'b1;
`endif
         e0 = run & req0_valid & (!req1_valid |  tb_last);
         e1 = run & req1_valid & (!req0_valid | !tb_last);
         pend0 = e0 & !req0_we;
         pend1 = e1 & !req1_we;
         if (run) begin
            chk("busy_run", busy, 0);
            if (req0_valid || req1_valid) begin
               chk("ready0", req0_ready, e0);
               chk("ready1", req1_ready, e1);
            end
            if (e0 && req0_we) begin
               chk("wr_en0", ram_wr_en, 1);
               chk("wr_addr0", ram_wr_addr, req0_addr);
               chk("wr_data0", ram_wr_data, req0_wdata);
               exp_mem[req0_addr] = req0_wdata;
            end else if (e1 && req1_we) begin
               chk("wr_en1", ram_wr_en, 1);
               chk("wr_addr1", ram_wr_addr, req1_addr);
               chk("wr_data1", ram_wr_data, req1_wdata);
               exp_mem[req1_addr] = req1_wdata;
            end else if (pend0) begin
               chk("rd_addr0", ram_rd_addr, req0_addr);
               chk("rd_wr_en0", ram_wr_en, 0);
               q0.push_back(exp_mem[req0_addr]);
            end else if (pend1) begin
               chk("rd_addr1", ram_rd_addr, req1_addr);
               chk("rd_wr_en1", ram_wr_en, 0);
               q1.push_back(exp_mem[req1_addr]);
            end else begin
               chk("idle_wr_en", ram_wr_en, 0);
               chk("idle_rd_addr", ram_rd_addr, 0);
               chk("idle_wr_addr", ram_wr_addr, 0);
            end
            if (e0) tb_last = 1'b0;
            else if (e1) tb_last = 1'b1;
         end
      end
   end

   // Drive one cycle of requests; called and returns at posedge+1.
   task automatic drive(input bit v0, input bit w0, input int a0, input int d0,
                        input bit v1, input bit w1, input int a1, input int d1);
      req0_valid = v0; req0_we = w0; req0_addr = AW'(a0); req0_wdata = WIDTH'(d0);
      req1_valid = v1; req1_we = w1; req1_addr = AW'(a1); req1_wdata = WIDTH'(d1);
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Pulse reset (or finish one already raised) and, with the sweep built,
   // measure how long busy stays high after release.
   task automatic do_reset();
      int n;
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
      n = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
      end
      chk("clear_len", n, DEPTH);
      @(posedge clk); #1;
`endif
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
      fill_en = 1'b1;
      @(posedge clk); #1 fill_en = 1'b0;
      do_reset();

      // single write then read by requester 0
      drive(1, 1, 3, 8'hA5, 0, 0, 0, 0);
      drive(1, 0, 3, 0,     0, 0, 0, 0);
      idle(2);

      // cross-requester read-after-write
      drive(0, 0, 0, 0, 1, 1, 7, 8'h3C);
      drive(1, 0, 7, 0, 0, 0, 0, 0);
      idle(2);

      // tie from reset: grants 0,1,0,1
      do_reset();
      drive(1, 1, 1, 8'h11, 1, 1, 2, 8'h22);
      drive(1, 1, 1, 8'h11, 1, 1, 2, 8'h22);
      for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 1, 0, 2, 0);
      idle(1);

      // stall: req1 loses the tie, fields consumed only when accepted
      drive(1, 0, 5, 0, 1, 1, 9, 8'h77);
      drive(0, 0, 0, 0, 1, 1, 9, 8'h77);
      drive(1, 0, 9, 0, 0, 0, 0, 0);
      idle(1);

      // randomized traffic with withdrawals on a small address window
      for (int i = 0; i < 300; i++)
         drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
      idle(2);

      // read accepted the cycle before reset yields no response
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      rst = 1'b1;
      req0_valid = 1'b0;
      @(negedge clk);
      chk("cancel_rsp0", rsp0_valid, 0);
      @(posedge clk); #1;
      do_reset();
      @(negedge clk);
      chk("cancel_after", rsp0_valid, 0);
      @(posedge clk); #1;
      drive(1, 0, 1, 0, 1, 0, 2, 0);
      drive(1, 0, 1, 0, 1, 0, 2, 0);
      idle(2);

`ifdef RAM_ARB_CLEAR_EN
      // preload 0xFF, reset, expect zeroes at the edges and middle
      fill_ff = 1'b1; fill_en = 1'b1;
      @(posedge clk); #1 fill_en = 1'b0;
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'hFF;
      do_reset();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 64, 0, 0, 0, 0, 0);
      drive(1, 0, 127, 0, 0, 0, 0, 0);
      idle(2);

      // reset at clr_addr 50 restarts the sweep with full length
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 51; i++) @(negedge clk);
      chk("sweep_at_50", ram_wr_addr, 50);
      @(posedge clk); #1;
      do_reset();
      drive(1, 0, 100, 0, 0, 0, 0, 0);
      idle(2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer in front of the single-write, single-read `block_ram`. It shares the RAM between two masters (e.g. program loader and core data path) with round-robin priority and a valid/ready request handshake. It returns read data through a registered, fixed-latency response channel. Optionally, it zero-fills the RAM after reset before granting any access.

## Interface
- `WIDTH`, 8: data width in bits; must match the attached RAM.
- `DEPTH`, 128: number of RAM words; must satisfy DEPTH ≤ 2^ADDR_WIDTH.
- `ADDR_WIDTH`, 8: address width in bits.

Clock and reset: one clock; reset is synchronous and active-high (`clk`, `rst`).

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `reqN_valid`  in  1  request N present (N = 0, 1).
- `reqN_we`  in  1  1 = write, 0 = read.
- `reqN_addr`  in  ADDR_WIDTH  word address.
- `reqN_wdata`  in  WIDTH  write data.
- `reqN_ready`  out  1  request N accepted this cycle.
- `rspN_valid`  out  1  read data for requester N valid (1-cycle pulse).
- `rspN_rdata`  out  WIDTH  read data for requester N.
- `ram_wr_en`  out  1  to RAM write enable.
- `ram_wr_addr`  out  ADDR_WIDTH  to RAM write address.
- `ram_wr_data`  out  WIDTH  to RAM write data.
- `ram_rd_addr`  out  ADDR_WIDTH  to RAM read address.
- `ram_rd_data`  in  WIDTH  from RAM; combinational read of `ram_rd_addr`.
- `busy`  out  1  clear sweep in progress; no grants while high.

## Operation
- States:
  - CLEAR exists only with `RAM_ARB_CLEAR_EN`.
  - RUN.
  - Reset enters CLEAR, if compiled in; otherwise it enters RUN.
- Arbitration in RUN:
  - At most one request is granted per cycle.
  - If only one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester not in `last_grant` is granted.
  - `last_grant` updates on every accepted request.
  - Reset value of `last_grant` = 1, so requester 0 wins the first tie.
- `reqN_ready` = granted & state==RUN; it is combinational from both valids. A request is accepted when valid & ready.
- Requesters hold valid/we/addr/wdata stable until accepted. Withdrawing an unaccepted request is allowed.
- Accepted write:
  - `ram_wr_en`=1, `ram_wr_addr`/`ram_wr_data` = granted fields, same cycle.
  - No response is generated.
- Accepted read:
  - `ram_rd_addr` = granted addr, same cycle.
  - `ram_rd_data` is captured into `rspN_rdata` at the edge.
  - `rspN_valid`=1 for exactly the next cycle.
- Responses cannot be back-pressured. `rspN_rdata` holds its last value when valid is low.
- Default drive values:
  - With no grant: `ram_wr_en`=0, `ram_rd_addr`=0.
  - `ram_wr_addr`/`ram_wr_data` are 0 when not writing.
- CLEAR:
  - Counter `clr_addr` (ADDR_WIDTH bits) starts at 0.
  - Each cycle the block writes 0 to `clr_addr` (`ram_wr_en`=1).
  - After writing address DEPTH-1, the block moves to RUN. The counter does not wrap.
  - All `reqN_ready`=0 while in CLEAR.
- Reset asserted mid-sweep or mid-operation:
  - Returns the block to the reset state.
  - The sweep restarts at address 0.
  - A pending `rspN_valid` is cancelled.
- Reset values:
  - `rspN_valid`=0, `rspN_rdata`=0, `reqN_ready`=0 during reset.
  - `ram_wr_en`=0 during reset.
  - `busy`: 1 with CLEAR, 0 without.

## Timing
- Grant: combinational, same cycle as valid.
- Read latency: accept in cycle T → `rspN_valid`/`rspN_rdata` in cycle T+1.
- Write visibility: write accepted in T is returned by a read accepted in T+1 or later.
- Back-to-back accepts are allowed every cycle. Each requester has at most one response in flight.
- Both requesters valid continuously: grants alternate 0,1,0,1… (throughput 1 op/cycle total).
- CLEAR duration: DEPTH cycles after reset deasserts. `busy` falls and the first grant is possible in cycle DEPTH (cycles counted from 0 after reset release).

## Configuration
- `RAM_ARB_CLEAR_EN` defined:
  - The CLEAR state and counter are built.
  - After every reset, the RAM is zero-filled over DEPTH cycles while `busy`=1.
- Undefined:
  - No CLEAR state; `busy` is tied 0.
  - Requests are granted from the first cycle after reset.
  - RAM contents are unaffected by reset.

## Test plan
- Single write then read: req0 writes 0xA5 to addr 3 in T; req0 reads addr 3 in T+1 → `rsp0_valid`=1 in T+2 with `rsp0_rdata`=0xA5; `rsp1_valid` stays 0.
- Tie: both requesters valid reading addrs 1 and 2 for 4 cycles after reset → grants 0,1,0,1; responses pulse on alternating cycles with the correct data.
- Stall: req1 held valid while req0 wins the tie → `req1_ready`=0 that cycle, 1 the next; req1 fields are consumed only at acceptance.
- Cross-requester RAW: req1 writes 0x3C to addr 7 while req0 idles; next cycle req0 reads addr 7 → `rsp0_rdata`=0x3C.
- Clear (macro on): preload RAM with 0xFF, pulse `rst`:
  - `busy`=1 and both readies 0 for 128 cycles.
  - Then reads of addrs 0, 64 and 127 return 0x00.
- Reset mid-sweep (macro on): assert `rst` at `clr_addr`=50 → after release, the sweep restarts at 0 and `busy` lasts the full 128 cycles; a read accepted the cycle before reset produces no response.
